// File: rtl/bnn_pkg.sv
// Shared types and derivation helpers for the time-multiplexed XNOR-popcount BNN engine.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L1   = 2'd1,
        ST_L2   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Counters need at least one bit even when they only ever hold zero.
    function automatic int cnt_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Popcount width: large enough to hold the full fan-in of either layer.
    function automatic int calc_tw(input int n_in, input int n_hid);
        return clog2(max2(n_in, n_hid) + 1);
    endfunction

    function automatic int calc_tc(input int tw, input int ld_w);
        return (tw + ld_w - 1) / ld_w;
    endfunction

endpackage

// File: rtl/bnn_xnor_neuron.sv
// Combinational binary neuron: fires when popcount(x XNOR w) reaches the threshold.
module bnn_xnor_neuron #(
    parameter int N  = 8,
    parameter int TW = 4
) (
    input  logic [N-1:0]  i_x,
    input  logic [N-1:0]  i_w,
    input  logic [TW-1:0] i_thr,
    output logic          o_fire
);

    logic [N-1:0]  w_match;
    logic [TW-1:0] w_sum;

    assign w_match = ~(i_x ^ i_w);

    // NOTE: combinational accumulation uses blocking '=' with a default first,
    // so the loop builds a chain of adders and no latch is inferred.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + TW'(w_match[i]);
        end
    end

    assign o_fire = (w_sum >= i_thr);

endmodule

// File: rtl/bnn_seq_engine.sv
// Two-layer BNN evaluated one neuron per cycle, with chunked runtime loading of weights/thresholds.
module bnn_seq_engine
    import bnn_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 4,
    parameter int LD_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             ld_valid,
    input  logic [LD_W-1:0]  ld_data,
    output logic             ld_ready,
    output logic             ld_done,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_data,
    input  logic             out_ready
);

    localparam int TW  = calc_tw(N_IN, N_HID);
    localparam int TC  = calc_tc(TW, LD_W);
    localparam int WC1 = N_IN / LD_W;
    localparam int WC2 = N_HID / LD_W;
    localparam int NC1 = WC1 + TC;
    localparam int NC2 = WC2 + TC;
    localparam int NN  = N_HID + N_OUT;
    localparam int PW  = cnt_width(NN);
    localparam int CW  = cnt_width(max2(NC1, NC2));
    localparam int KW  = cnt_width(max2(N_HID, N_OUT));
    localparam int HW  = cnt_width(N_HID);
    localparam int OW  = cnt_width(N_OUT);

    // Parameter storage
    logic [N_IN-1:0]  r_w1   [N_HID];
    logic [TW-1:0]    r_thr1 [N_HID];
    logic [N_HID-1:0] r_w2   [N_OUT];
    logic [TW-1:0]    r_thr2 [N_OUT];

    // Control and datapath state
    state_t           r_state;
    logic [KW-1:0]    r_cnt;
    logic [N_IN-1:0]  r_x;
    logic [N_HID-1:0] r_hidden;
    logic [N_OUT-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_ld_done;
    logic [PW-1:0]    r_ld_nrn;
    logic [CW-1:0]    r_ld_chk;

    logic             w_ld_fire;
    logic             w_in_fire;
    logic [CW-1:0]    w_chk_last;
    logic             w_fire1;
    logic             w_fire2;
    logic [N_IN-1:0]  w_w1_row;
    logic [TW-1:0]    w_thr1_row;
    logic [N_HID-1:0] w_w2_row;
    logic [TW-1:0]    w_thr2_row;

    assign ld_ready  = ena && (r_state == ST_IDLE);
    assign in_ready  = ena && (r_state == ST_IDLE) && !ld_valid;
    assign w_ld_fire = ld_valid && ld_ready;
    assign w_in_fire = in_valid && in_ready;

    assign ld_done   = r_ld_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    assign w_chk_last = (r_ld_nrn < PW'(N_HID)) ? CW'(NC1 - 1) : CW'(NC2 - 1);

    // The shared neuron of each layer sees the row selected by the sequencing counter.
    assign w_w1_row   = r_w1[r_cnt[HW-1:0]];
    assign w_thr1_row = r_thr1[r_cnt[HW-1:0]];
    assign w_w2_row   = r_w2[r_cnt[OW-1:0]];
    assign w_thr2_row = r_thr2[r_cnt[OW-1:0]];

    bnn_xnor_neuron #(
        .N  (N_IN),
        .TW (TW)
    ) u_l1_neuron (
        .i_x    (r_x),
        .i_w    (w_w1_row),
        .i_thr  (w_thr1_row),
        .o_fire (w_fire1)
    );

    bnn_xnor_neuron #(
        .N  (N_HID),
        .TW (TW)
    ) u_l2_neuron (
        .i_x    (r_hidden),
        .i_w    (w_w2_row),
        .i_thr  (w_thr2_row),
        .o_fire (w_fire2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the weight/threshold arrays are flops, not SRAM, so they are
            // reset explicitly to give a usable default network after reset.
            for (int j = 0; j < N_HID; j++) begin
                r_w1[j]   <= '0;
                r_thr1[j] <= TW'(N_IN / 2);
            end
            for (int j = 0; j < N_OUT; j++) begin
                r_w2[j]   <= '0;
                r_thr2[j] <= TW'(N_HID / 2);
            end
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_hidden    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ld_done   <= 1'b0;
            r_ld_nrn    <= '0;
            r_ld_chk    <= '0;
        end else if (ena) begin
            r_ld_done <= 1'b0;

            if (w_ld_fire) begin
                // Chunk k of a neuron covers bits [k*LD_W +: LD_W]; threshold bits above TW are dropped.
                for (int j = 0; j < N_HID; j++) begin
                    if (r_ld_nrn == PW'(j)) begin
                        for (int b = 0; b < N_IN; b++) begin
                            if (r_ld_chk == CW'(b / LD_W)) r_w1[j][b] <= ld_data[b % LD_W];
                        end
                        for (int b = 0; b < TW; b++) begin
                            if (r_ld_chk == CW'(WC1 + b / LD_W)) r_thr1[j][b] <= ld_data[b % LD_W];
                        end
                    end
                end
                for (int j = 0; j < N_OUT; j++) begin
                    if (r_ld_nrn == PW'(N_HID + j)) begin
                        for (int b = 0; b < N_HID; b++) begin
                            if (r_ld_chk == CW'(b / LD_W)) r_w2[j][b] <= ld_data[b % LD_W];
                        end
                        for (int b = 0; b < TW; b++) begin
                            if (r_ld_chk == CW'(WC2 + b / LD_W)) r_thr2[j][b] <= ld_data[b % LD_W];
                        end
                    end
                end

                if (r_ld_chk == w_chk_last) begin
                    r_ld_chk <= '0;
                    if (r_ld_nrn == PW'(NN - 1)) begin
                        r_ld_nrn  <= '0;
                        r_ld_done <= 1'b1;
                    end else begin
                        r_ld_nrn <= r_ld_nrn + 1'b1;
                    end
                end else begin
                    r_ld_chk <= r_ld_chk + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_x     <= in_data;
                        r_cnt   <= '0;
                        r_state <= ST_L1;
                    end
                end
                ST_L1: begin
                    r_hidden[r_cnt[HW-1:0]] <= w_fire1;
                    if (r_cnt == KW'(N_HID - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_L2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_L2: begin
                    r_out_data[r_cnt[OW-1:0]] <= w_fire2;
                    if (r_cnt == KW'(N_OUT - 1)) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
